acc_program_sequencer: RTL and testbench
========================================

// Module: acc_program_sequencer
//
// PURPOSE
//   Sequences the 8-bit accumulator datapath (ADD/SUB/AND/OR/NOT on regA).
//   Holds a small program of 8-bit words, each {operand[7:4], opcode[3:0]}, loaded serially.
//   After start it fetches, decodes and issues one ALU command per instruction over a valid/ready handshake.
//   Handles NOP, conditional branch (JNZ) and HALT locally; the datapath never sees them.
//
// PARAMETERS
//   DEPTH  16  program memory entries (power of two, 2..16)
//   AW     4   address width, $clog2(DEPTH)
//
// PORTS
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous reset, active-high
//   load_valid   in   1   write load_data to mem[wr_ptr] (IDLE/HALTED only)
//   load_data    in   8   program word {operand, opcode}
//   start        in   1   begin execution at pc=0 (IDLE/HALTED only)
//   cmd_valid    out  1   ALU command valid
//   cmd_ready    in   1   datapath accepts command
//   cmd_op       out  4   opcode 1..5 (ADD,SUB,AND,OR,NOT)
//   cmd_operand  out  4   operand nibble
//   acc_zero     in   1   datapath regA == 0
//   pc           out  AW  current program counter
//   busy         out  1   state in FETCH/EXEC/ISSUE
//   halted       out  1   HALT executed, not yet restarted
//
// BEHAVIOUR
//   - Reset: state=IDLE, pc=0, wr_ptr=0, cmd_valid=0, cmd_op=0, cmd_operand=0, busy=0, halted=0.
//   - Memory is not cleared by reset.
//   - States: IDLE, FETCH, EXEC, ISSUE, HALTED.
//   - IDLE/HALTED:
//       load_valid -> mem[wr_ptr]<=load_data; wr_ptr++ (wraps DEPTH-1 -> 0).
//       start -> FETCH, pc<=0, wr_ptr<=0, halted<=0.
//       load_valid and start in the same cycle: the load is performed, start is ignored.
//   - FETCH: mem[pc] is read synchronously -> EXEC.
//   - EXEC: decodes the fetched word.
//       op 1..5: cmd_valid<=1, cmd_op/operand driven -> ISSUE.
//       op 0 or 8..15: NOP, pc++ -> FETCH.
//       op 6 (JNZ): acc_zero==0 -> pc<=operand (zero-extended/truncated to AW); else pc++ -> FETCH.
//       op 7 (HALT): -> HALTED, halted<=1, pc holds.
//   - ISSUE: cmd_valid and payload held stable until cmd_ready.
//       On cmd_valid&&cmd_ready: cmd_valid<=0, pc++ -> FETCH.
//   - Latency: start -> cmd_valid asserted on cycle 3 (FETCH, EXEC, then registered).
//   - Issued command to next issue: minimum 3 cycles.
//   - Datapath must update acc_zero within 1 cycle of handshake; JNZ samples acc_zero in EXEC, >=2 cycles later.
//   - pc increment wraps DEPTH-1 -> 0.
//   - load_valid/start while busy are ignored.
//   - rst asserted in any state, including mid-ISSUE: cmd_valid=0 on the next edge, full reset values.
//   - busy = (state inside FETCH/EXEC/ISSUE); combinational from the state register.
//
// CONFIGURATION
//   SEQ_SINGLE_STEP_EN
//     Defined: adds input `step` (1 bit). FETCH -> EXEC only in a cycle with step=1.
//       One instruction executes per step pulse; step is ignored in other states.
//     Undefined: no step port; FETCH always advances the next cycle.
//
// STRUCTURE
//   - acc_seq_pkg: opcode localparams (OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_NOT=5,
//     OP_JNZ=6, OP_HALT=7) and the state encoding; shared with the datapath.
//   - Sub-module seq_prog_mem: DEPTH x 8 RAM, 1 write port, 1 synchronous read port, no reset.
//   - FSM, pc and wr_ptr stay in the top level.
//
// TESTING
//   1. Load 0x31, 0x07; start; cmd_ready=1 -> one command op=1 operand=3, cmd_valid high on cycle 3
//      after start for 1 cycle; then halted=1, pc=1, busy=0.
//   2. Load 0x52, 0x07; cmd_ready low 5 cycles -> cmd_valid held, op=2 operand=5 stable, pc=0;
//      ready high -> accepted once, then HALT.
//   3. Datapath model regA=3; load 0x12, 0x06, 0x07 -> exactly 3 SUB-1 commands issued; pc ends at 2; halted=1.
//   4. DEPTH=16; 17 loads with values 0x00..0x10 -> mem[0]=0x10, mem[1]=0x01; wr_ptr=1.
//   5. rst pulsed while in ISSUE (cmd_ready=0) -> next cycle cmd_valid=0, pc=0, busy=0;
//      restart reruns the retained program identically.
//   6. SEQ_SINGLE_STEP_EN defined, program 0x11, 0x11, 0x07 -> no command until step;
//      each step pulse yields exactly one command; third step halts.
//   - Also: start+load_valid in the same cycle -> word written, busy stays 0.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// Opcode and state encodings shared by the program sequencer and the accumulator datapath.
package acc_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_JNZ  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    typedef struct packed {
        logic [3:0] operand;
        logic [3:0] opcode;
    } instr_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/acc_program_sequencer_mem.sv
// Program store: DEPTH x 8 RAM, one write port, one registered read port, contents survive reset.
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/acc_program_sequencer.sv
// Fetch/decode/issue sequencer for the accumulator datapath; NOP, JNZ and HALT are resolved locally.
// Optional SEQ_SINGLE_STEP_EN adds a `step` input gating FETCH -> EXEC.
module acc_program_sequencer
    import acc_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic          step,
`endif
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          start,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [3:0]    cmd_op,
    output logic [3:0]    cmd_operand,
    input  logic          acc_zero,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [3:0]    cmd_op_q, cmd_op_d;
    logic [3:0]    cmd_operand_q, cmd_operand_d;
    logic          halted_q, halted_d;
    logic [7:0]    rdata;
    instr_t        fetched;
    logic          idle_like, mem_we, mem_re, fetch_go;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALTED);
    assign mem_we    = idle_like && load_valid;
    assign mem_re    = (state_q == ST_FETCH);
    assign fetched   = instr_t'(rdata);
    assign pc_inc    = pc_q + AW'(1);

`ifdef SEQ_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_data),
        .re_i    (mem_re),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_op_d      = cmd_op_q;
        cmd_operand_d = cmd_operand_q;
        halted_d      = halted_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                // A load in the same cycle as start wins; start is dropped.
                if (load_valid) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end else if (start) begin
                    state_d  = ST_FETCH;
                    pc_d     = '0;
                    wr_ptr_d = '0;
                    halted_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (fetch_go) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_alu_op(fetched.opcode)) begin
                    cmd_valid_d   = 1'b1;
                    cmd_op_d      = fetched.opcode;
                    cmd_operand_d = fetched.operand;
                    state_d       = ST_ISSUE;
                end else if (fetched.opcode == OP_JNZ) begin
                    pc_d    = acc_zero ? pc_inc : fetched.operand[AW-1:0];
                    state_d = ST_FETCH;
                end else if (fetched.opcode == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end else begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    pc_d        = pc_inc;
                    state_d     = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            wr_ptr_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= '0;
            cmd_operand_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_op_q      <= cmd_op_d;
            cmd_operand_q <= cmd_operand_d;
            halted_q      <= halted_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_operand = cmd_operand_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_ISSUE);

endmodule

// File: tb/tb_acc_program_sequencer.sv
// Self-checking bench for acc_program_sequencer with an accumulator datapath model and an
// instruction-level reference interpreter; the step scenario is built when SEQ_SINGLE_STEP_EN is defined.
module tb_acc_program_sequencer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, load_valid, start, cmd_ready, step;
    logic [7:0] load_data;
    logic       cmd_valid, busy, halted, acc_zero;
    logic [3:0] cmd_op, cmd_operand, pc;

    int checks = 0;
    int passed = 0;

    // Datapath model and handshake log
    logic [7:0] regA = 8'h00;
    logic [7:0] regA_init = 8'h00;
    logic       dp_load = 1'b0;
    logic [7:0] hs_q[$];

    // Reference program image and interpreter results
    logic [7:0] prog [DEPTH];
    int         wrp;
    logic [7:0] exp_q[$];
    int         exp_pc;

    always #5 clk = ~clk;

    acc_program_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .load_valid  (load_valid),
        .load_data   (load_data),
        .start       (start),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .acc_zero    (acc_zero),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [3:0] opd, input logic [7:0] a);
        case (op)
            4'd1:    return a + {4'h0, opd};
            4'd2:    return a - {4'h0, opd};
            4'd3:    return a & {4'h0, opd};
            4'd4:    return a | {4'h0, opd};
            4'd5:    return ~a;
            default: return a;
        endcase
    endfunction

    assign acc_zero = (regA == 8'h00);

    always @(posedge clk) begin
        if (dp_load) begin
            regA <= regA_init;
        end else if (cmd_valid && cmd_ready) begin
            regA <= alu(cmd_op, cmd_operand, regA);
            hs_q.push_back({cmd_op, cmd_operand});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wrp = 0;
    endtask

    task automatic set_acc(input logic [7:0] v);
        regA_init = v;
        dp_load   = 1'b1;
        tick();
        dp_load   = 1'b0;
        hs_q.delete();
    endtask

    task automatic load_word(input logic [7:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
        prog[wrp]  = w;
        wrp        = (wrp + 1) % DEPTH;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halted(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Instruction-level interpreter over prog[]; ok=0 if no HALT within the step limit.
    task automatic model_exec(input logic [7:0] a0, output int ok);
        int         p = 0;
        int         n = 0;
        logic [7:0] a = a0;
        logic [3:0] op, opd;
        exp_q.delete();
        ok = 0;
        while (n < 200) begin
            op  = prog[p][3:0];
            opd = prog[p][7:4];
            n++;
            if (op >= 4'd1 && op <= 4'd5) begin
                exp_q.push_back({op, opd});
                a = alu(op, opd, a);
                p = (p + 1) % DEPTH;
            end else if (op == 4'd6) begin
                p = (a != 8'h00) ? int'(opd) % DEPTH : (p + 1) % DEPTH;
            end else if (op == 4'd7) begin
                exp_pc = p;
                ok = 1;
                return;
            end else begin
                p = (p + 1) % DEPTH;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", cmd_valid); else passed++;
        checks++; if ({cmd_op, cmd_operand} !== 8'h00) $display("FAIL reset_payload got=%h exp=00", {cmd_op, cmd_operand}); else passed++;
        checks++; if (pc !== 4'd0) $display("FAIL reset_pc got=%0d exp=0", pc); else passed++;
        checks++; if ({busy, halted} !== 2'b00) $display("FAIL reset_busy_halted got=%b exp=00", {busy, halted}); else passed++;
        rst = 1'b0;
        wrp = 0;
    endtask

    task automatic test_basic();
        int lat;
        do_reset();
        set_acc(8'h00);
        cmd_ready = 1'b1;
        load_word(8'h31);
        load_word(8'h07);
        pulse_start();
        lat = 1;
        while (!cmd_valid && lat < 10) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 3) $display("FAIL basic_latency got=%0d exp=3", lat); else passed++;
        checks++; if ({cmd_op, cmd_operand} !== 8'h13) $display("FAIL basic_payload got=%h exp=13", {cmd_op, cmd_operand}); else passed++;
        tick();
        checks++; if (cmd_valid !== 1'b0) $display("FAIL basic_valid_one_cycle got=%0b exp=0", cmd_valid); else passed++;
        wait_halted(20);
        checks++; if ({halted, busy} !== 2'b10) $display("FAIL basic_halted_busy got=%b exp=10", {halted, busy}); else passed++;
        checks++; if (pc !== 4'd1) $display("FAIL basic_pc got=%0d exp=1", pc); else passed++;
        checks++; if (hs_q.size() !== 1) $display("FAIL basic_cmd_count got=%0d exp=1", hs_q.size()); else passed++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        set_acc(8'h00);
        cmd_ready = 1'b0;
        load_word(8'h52);
        load_word(8'h07);
        pulse_start();
        while (!cmd_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({cmd_valid, cmd_op, cmd_operand, pc} !== {1'b1, 4'd2, 4'd5, 4'd0})
                $display("FAIL stall_hold cyc=%0d got v=%0b op=%0d opd=%0d pc=%0d exp v=1 op=2 opd=5 pc=0",
                         i, cmd_valid, cmd_op, cmd_operand, pc);
            else passed++;
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        wait_halted(20);
        checks++; if (hs_q.size() !== 1) $display("FAIL stall_cmd_count got=%0d exp=1", hs_q.size()); else passed++;
        checks++; if (hs_q.size() > 0 && hs_q[0] !== 8'h25) $display("FAIL stall_cmd got=%h exp=25", hs_q[0]); else passed++;
        checks++; if ({halted, pc} !== {1'b1, 4'd1}) $display("FAIL stall_end got h=%0b pc=%0d exp h=1 pc=1", halted, pc); else passed++;
    endtask

    task automatic test_jnz_loop();
        do_reset();
        set_acc(8'h03);
        cmd_ready = 1'b1;
        load_word(8'h12);
        load_word(8'h06);
        load_word(8'h07);
        pulse_start();
        wait_halted(100);
        checks++; if (hs_q.size() !== 3) $display("FAIL jnz_cmd_count got=%0d exp=3", hs_q.size()); else passed++;
        for (int i = 0; i < hs_q.size() && i < 3; i++) begin
            checks++; if (hs_q[i] !== 8'h21) $display("FAIL jnz_cmd%0d got=%h exp=21", i, hs_q[i]); else passed++;
        end
        checks++; if ({halted, pc} !== {1'b1, 4'd2}) $display("FAIL jnz_end got h=%0b pc=%0d exp h=1 pc=2", halted, pc); else passed++;
        checks++; if (regA !== 8'h00) $display("FAIL jnz_regA got=%h exp=00", regA); else passed++;
    endtask

    task automatic test_load_wrap();
        do_reset();
        set_acc(8'h00);
        cmd_ready = 1'b1;
        for (int i = 0; i <= 16; i++) load_word(8'(i));
        // wr_ptr has wrapped to 1, so this HALT lands behind the NOP at mem[0]
        load_word(8'h07);
        pulse_start();
        wait_halted(30);
        checks++; if ({halted, pc} !== {1'b1, 4'd1}) $display("FAIL wrap_end got h=%0b pc=%0d exp h=1 pc=1", halted, pc); else passed++;
        checks++; if (hs_q.size() !== 0) $display("FAIL wrap_cmd_count got=%0d exp=0", hs_q.size()); else passed++;
    endtask

    task automatic test_reset_mid_issue();
        int n = 0;
        do_reset();
        set_acc(8'h00);
        cmd_ready = 1'b0;
        load_word(8'h31);
        load_word(8'h07);
        pulse_start();
        while (!cmd_valid && n < 10) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_valid, pc, busy, halted} !== {1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL midrst got v=%0b pc=%0d busy=%0b h=%0b exp v=0 pc=0 busy=0 h=0", cmd_valid, pc, busy, halted);
        else passed++;
        hs_q.delete();
        cmd_ready = 1'b1;
        pulse_start();
        wait_halted(30);
        checks++; if (hs_q.size() !== 1 || hs_q[0] !== 8'h13) $display("FAIL midrst_rerun got n=%0d exp n=1 cmd=13", hs_q.size()); else passed++;
        checks++; if ({halted, pc} !== {1'b1, 4'd1}) $display("FAIL midrst_end got h=%0b pc=%0d exp h=1 pc=1", halted, pc); else passed++;
    endtask

    task automatic test_load_start_same_cycle();
        do_reset();
        set_acc(8'h00);
        cmd_ready  = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h07;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        prog[0]    = 8'h07;
        wrp        = 1;
        checks++; if (busy !== 1'b0) $display("FAIL ldst_busy got=%0b exp=0", busy); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL ldst_busy2 got=%0b exp=0", busy); else passed++;
        pulse_start();
        wait_halted(20);
        checks++; if ({halted, pc} !== {1'b1, 4'd0}) $display("FAIL ldst_end got h=%0b pc=%0d exp h=1 pc=0", halted, pc); else passed++;
        checks++; if (hs_q.size() !== 0) $display("FAIL ldst_cmd_count got=%0d exp=0", hs_q.size()); else passed++;
    endtask

    task automatic test_random_programs();
        int         ok, tries, n;
        logic [3:0] op;
        logic [7:0] a0;
        for (int it = 0; it < 20; it++) begin
            ok    = 0;
            tries = 0;
            while (!ok && tries < 100) begin
                for (int j = 0; j < DEPTH; j++) begin
                    op = 4'($urandom_range(0, 8));
                    if (op == 4'd8) op = 4'($urandom_range(8, 15));
                    prog[j] = {4'($urandom_range(0, 15)), op};
                end
                a0 = 8'($urandom_range(0, 255));
                model_exec(a0, ok);
                tries++;
            end
            do_reset();
            set_acc(a0);
            cmd_ready = 1'b0;
            for (int j = 0; j < DEPTH; j++) load_word(prog[j]);
            pulse_start();
            n = 0;
            while (!halted && n < 3000) begin
                cmd_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            cmd_ready = 1'b0;
            checks++; if (hs_q.size() !== exp_q.size()) $display("FAIL rand%0d_count got=%0d exp=%0d", it, hs_q.size(), exp_q.size()); else passed++;
            for (int k = 0; k < hs_q.size() && k < exp_q.size(); k++) begin
                checks++; if (hs_q[k] !== exp_q[k]) $display("FAIL rand%0d_cmd%0d got=%h exp=%h", it, k, hs_q[k], exp_q[k]); else passed++;
            end
            checks++; if ({halted, pc} !== {1'b1, 4'(exp_pc)}) $display("FAIL rand%0d_end got h=%0b pc=%0d exp h=1 pc=%0d", it, halted, pc, exp_pc); else passed++;
        end
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        do_reset();
        set_acc(8'h00);
        cmd_ready = 1'b1;
        step      = 1'b0;
        load_word(8'h11);
        load_word(8'h11);
        load_word(8'h07);
        pulse_start();
        for (int i = 0; i < 8; i++) tick();
        checks++; if ({hs_q.size() == 0, busy, pc} !== {1'b1, 1'b1, 4'd0}) $display("FAIL step_idle got n=%0d busy=%0b pc=%0d exp n=0 busy=1 pc=0", hs_q.size(), busy, pc); else passed++;
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            for (int i = 0; i < 6; i++) tick();
            checks++; if (hs_q.size() !== k + 1) $display("FAIL step%0d_count got=%0d exp=%0d", k, hs_q.size(), k + 1); else passed++;
        end
        checks++; if (halted !== 1'b0) $display("FAIL step_early_halt got=%0b exp=0", halted); else passed++;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_halted(10);
        checks++; if ({halted, pc, hs_q.size() == 2} !== {1'b1, 4'd2, 1'b1}) $display("FAIL step_end got h=%0b pc=%0d n=%0d exp h=1 pc=2 n=2", halted, pc, hs_q.size()); else passed++;
        step = 1'b1;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        start      = 1'b0;
        cmd_ready  = 1'b0;
        step       = 1'b1;
        wrp        = 0;
        exp_pc     = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_jnz_loop();
        test_load_wrap();
        test_reset_mid_issue();
        test_load_start_same_cycle();
        test_random_programs();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
